// File: rtl/spi_link.sv
`default_nettype none
// ============================================================================
// Module   : spi_link
// Purpose  : SPI mode-0 master, NSLAVE slaves and one-hot MISO return mux
//            in a single clock domain.
// Revision : 1.0
// ============================================================================
module spi_link #(
    parameter int NSLAVE  = 2,
    parameter int CLK_DIV = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NSLAVE-1:0]   sel,
    input  logic [7:0]          master_din,
    output logic [7:0]          master_dout,
    output logic                master_new_data,
    output logic                busy,
    input  logic [8*NSLAVE-1:0] slave_din,
    output logic [8*NSLAVE-1:0] slave_dout,
    output logic [NSLAVE-1:0]   slave_done,
    output logic                sck,
    output logic                mosi,
    output logic                miso
);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_HALF = 2'd1;
    localparam logic [1:0] S_TRANSFER  = 2'd2;

    localparam logic [CLK_DIV-1:0] C_HALF_LAST = {1'b0, {(CLK_DIV-1){1'b1}}};
    localparam logic [CLK_DIV-1:0] C_FULL_LAST = {CLK_DIV{1'b1}};

    logic [1:0]         state_q, state_d;
    logic [CLK_DIV-1:0] cnt_q, cnt_d;
    logic [7:0]         tx_q, tx_d;
    logic [7:0]         rx_q, rx_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         dout_q, dout_d;
    logic               new_data_q, new_data_d;
    logic               w_start;
    logic               w_last_fall;
    logic [NSLAVE-1:0]  w_slave_miso;

    assign w_start     = |sel;
    assign w_last_fall = (cnt_q == C_FULL_LAST) && (bit_q == 3'd7);
    assign miso        = |(sel & w_slave_miso);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_q      <= '0;
            dout_q     <= '0;
            new_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_q      <= bit_d;
            dout_q     <= dout_d;
            new_data_q <= new_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (w_start) state_d = S_WAIT_HALF;
            S_WAIT_HALF: if (cnt_q == C_HALF_LAST) state_d = S_TRANSFER;
            S_TRANSFER:  if (w_last_fall) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Divider, shift registers and byte completion; sck edges are cnt_q roll points.
    always_comb begin
        cnt_d      = cnt_q + 1'b1;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_d      = bit_q;
        dout_d     = dout_q;
        new_data_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (w_start) begin
                    tx_d  = master_din;
                    bit_d = '0;
                end
            end
            S_WAIT_HALF: begin
                if (cnt_q == C_HALF_LAST) cnt_d = '0;
            end
            S_TRANSFER: begin
                if (cnt_q == C_HALF_LAST) rx_d = {rx_q[6:0], miso};
                if (cnt_q == C_FULL_LAST) begin
                    tx_d  = {tx_q[6:0], 1'b0};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        dout_d     = rx_q;
                        new_data_d = 1'b1;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_comb begin
        sck             = (state_q == S_TRANSFER) & cnt_q[CLK_DIV-1];
        busy            = (state_q != S_IDLE);
        mosi            = tx_q[7];
        master_dout     = dout_q;
        master_new_data = new_data_q;
    end

    for (genvar gi = 0; gi < NSLAVE; gi++) begin : g_slave
        logic       sl_ss_n_q, sl_sck1_q, sl_sck2_q, sl_mosi_q;
        logic [7:0] sl_sh_q, sl_sh_d;
        logic [2:0] sl_cnt_q, sl_cnt_d;
        logic       sl_miso_q, sl_miso_d;
        logic [7:0] sl_dout_q, sl_dout_d;
        logic       sl_done_q, sl_done_d;
        logic [7:0] w_din;
        logic       w_rise, w_fall;

        assign w_din  = slave_din[8*gi +: 8];
        assign w_rise = sl_sck1_q & ~sl_sck2_q;
        assign w_fall = ~sl_sck1_q & sl_sck2_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sl_ss_n_q <= 1'b1;
                sl_sck1_q <= 1'b0;
                sl_sck2_q <= 1'b0;
                sl_mosi_q <= 1'b0;
                sl_sh_q   <= '0;
                sl_cnt_q  <= '0;
                sl_miso_q <= 1'b0;
                sl_dout_q <= '0;
                sl_done_q <= 1'b0;
            end else begin
                sl_ss_n_q <= ~sel[gi];
                sl_sck1_q <= sck;
                sl_sck2_q <= sl_sck1_q;
                sl_mosi_q <= mosi;
                sl_sh_q   <= sl_sh_d;
                sl_cnt_q  <= sl_cnt_d;
                sl_miso_q <= sl_miso_d;
                sl_dout_q <= sl_dout_d;
                sl_done_q <= sl_done_d;
            end
        end

        // Reloading on the 8th rise lets the next frame's MSB go out on the 8th fall.
        always_comb begin
            sl_sh_d   = sl_sh_q;
            sl_cnt_d  = sl_cnt_q;
            sl_miso_d = sl_miso_q;
            sl_dout_d = sl_dout_q;
            sl_done_d = 1'b0;
            if (sl_ss_n_q) begin
                sl_cnt_d  = '0;
                sl_sh_d   = w_din;
                sl_miso_d = w_din[7];
            end else begin
                if (w_rise) begin
                    if (sl_cnt_q == 3'd7) begin
                        sl_dout_d = {sl_sh_q[6:0], sl_mosi_q};
                        sl_done_d = 1'b1;
                        sl_sh_d   = w_din;
                        sl_cnt_d  = '0;
                    end else begin
                        sl_sh_d  = {sl_sh_q[6:0], sl_mosi_q};
                        sl_cnt_d = sl_cnt_q + 3'd1;
                    end
                end
                if (w_fall) sl_miso_d = sl_sh_q[7];
            end
        end

        assign slave_dout[8*gi +: 8] = sl_dout_q;
        assign slave_done[gi]        = sl_done_q;
        assign w_slave_miso[gi]      = sl_miso_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_link.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_link
// Purpose  : Directed self-checking bench for spi_link (NSLAVE=2, CLK_DIV=3).
// Revision : 1.0
// ============================================================================
module tb_spi_link;
    localparam int NSLAVE  = 2;
    localparam int CLK_DIV = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic [7:0]  master_din;
    logic [7:0]  master_dout;
    logic        master_new_data;
    logic        busy;
    logic [15:0] slave_din;
    logic [15:0] slave_dout;
    logic [1:0]  slave_done;
    logic        sck, mosi, miso;

    spi_link #(.NSLAVE(NSLAVE), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .sel(sel),
        .master_din(master_din), .master_dout(master_dout),
        .master_new_data(master_new_data), .busy(busy),
        .slave_din(slave_din), .slave_dout(slave_dout), .slave_done(slave_done),
        .sck(sck), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    int n_asserts  = 0;
    int n_failures = 0;
    int cyc        = 0;
    int nd_cnt     = 0;
    int d0_cnt     = 0;
    int d1_cnt     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (master_new_data) nd_cnt++;
        if (slave_done[0])   d0_cnt++;
        if (slave_done[1])   d1_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_failures++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic start_frame(input logic [1:0] s, input logic [7:0] d, output int c0);
        @(negedge clk);
        master_din = d;
        sel        = s;
        c0         = cyc;
    endtask

    // Waits for master_new_data, drops sel in that idle cycle, returns latency.
    task automatic wait_new_data(input int c0, output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (master_new_data) begin
                lat = cyc - c0;
                sel = 2'b00;
                break;
            end
        end
    endtask

    int c0, lat, snd, sd0, sd1, k, low;
    int t[3];

    initial begin
        rst        = 1'b1;
        sel        = 2'b00;
        master_din = 8'h00;
        slave_din  = {8'h55, 8'hAA};
        repeat (3) @(negedge clk);
        check_eq("rst_mdout", master_dout, 32'h0);
        check_eq("rst_sdout", slave_dout, 32'h0);
        check_eq("rst_bits", {busy, master_new_data, slave_done, sck, mosi, miso}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Slave 1 only
        snd = nd_cnt; sd0 = d0_cnt; sd1 = d1_cnt;
        start_frame(2'b10, 8'hA5, c0);
        wait_new_data(c0, lat);
        check_eq("s1_latency", lat, 69);
        check_eq("s1_mdout", master_dout, 32'h55);
        repeat (8) @(negedge clk);
        check_eq("s1_sdout1", slave_dout[15:8], 32'hA5);
        check_eq("s1_sdout0", slave_dout[7:0], 32'h00);
        check_eq("s1_done1_cnt", d1_cnt - sd1, 1);
        check_eq("s1_done0_cnt", d0_cnt - sd0, 0);
        check_eq("s1_nd_cnt", nd_cnt - snd, 1);

        // Slave 0 only
        snd = nd_cnt; sd0 = d0_cnt;
        start_frame(2'b01, 8'hA5, c0);
        wait_new_data(c0, lat);
        check_eq("s0_latency", lat, 69);
        check_eq("s0_mdout", master_dout, 32'hAA);
        check_eq("s0_busy_ndcycle", busy, 1'b0);
        repeat (8) @(negedge clk);
        check_eq("s0_sdout0", slave_dout[7:0], 32'hA5);
        check_eq("s0_done0_cnt", d0_cnt - sd0, 1);
        check_eq("s0_nd_cnt", nd_cnt - snd, 1);

        // Three back-to-back frames with sel held
        snd = nd_cnt; sd0 = d0_cnt;
        @(negedge clk);
        master_din = 8'h3C;
        sel        = 2'b01;
        k = 0; low = 0;
        for (int i = 0; i < 400 && k < 3; i++) begin
            @(negedge clk);
            if (!busy) low++;
            if (master_new_data) begin
                t[k] = cyc;
                k++;
                if (k == 3) sel = 2'b00;
            end
        end
        check_eq("b2b_frames", k, 3);
        check_eq("b2b_space01", t[1] - t[0], 69);
        check_eq("b2b_space12", t[2] - t[1], 69);
        check_eq("b2b_busy_low", low, 3);
        repeat (8) @(negedge clk);
        check_eq("b2b_nd_cnt", nd_cnt - snd, 3);
        check_eq("b2b_done0_cnt", d0_cnt - sd0, 3);
        check_eq("b2b_sdout0", slave_dout[7:0], 32'h3C);
        check_eq("b2b_mdout", master_dout, 32'hAA);

        // No selection, every slave driving 1
        slave_din = 16'hFFFF;
        repeat (3) @(negedge clk);
        snd = nd_cnt; sd0 = d0_cnt; sd1 = d1_cnt;
        check_eq("idle_miso", miso, 1'b0);
        check_eq("idle_busy", busy, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("idle_strobes", (nd_cnt - snd) + (d0_cnt - sd0) + (d1_cnt - sd1), 0);
        check_eq("idle_sck", sck, 1'b0);
        slave_din = {8'h55, 8'hAA};
        repeat (2) @(negedge clk);

        // Reset in the middle of bit 4
        start_frame(2'b01, 8'hA5, c0);
        repeat (38) @(negedge clk);
        snd = nd_cnt; sd0 = d0_cnt;
        rst = 1'b1;
        sel = 2'b00;
        @(negedge clk);
        check_eq("mrst_bits", {busy, master_new_data, slave_done, sck, mosi, miso}, 32'h0);
        check_eq("mrst_mdout", master_dout, 32'h0);
        check_eq("mrst_sdout", slave_dout, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("mrst_strobes", (nd_cnt - snd) + (d0_cnt - sd0), 0);
        snd = nd_cnt; sd0 = d0_cnt;
        start_frame(2'b01, 8'hA5, c0);
        wait_new_data(c0, lat);
        check_eq("post_rst_latency", lat, 69);
        check_eq("post_rst_mdout", master_dout, 32'hAA);
        repeat (8) @(negedge clk);
        check_eq("post_rst_sdout0", slave_dout[7:0], 32'hA5);
        check_eq("post_rst_done0_cnt", d0_cnt - sd0, 1);

        // Deselect after bit 3: slave aborts, master still finishes
        snd = nd_cnt; sd0 = d0_cnt;
        start_frame(2'b01, 8'h0F, c0);
        repeat (30) @(negedge clk);
        sel = 2'b00;
        wait_new_data(c0, lat);
        check_eq("abort_latency", lat, 69);
        repeat (20) @(negedge clk);
        check_eq("abort_nd_cnt", nd_cnt - snd, 1);
        check_eq("abort_done0_cnt", d0_cnt - sd0, 0);
        check_eq("abort_sdout0", slave_dout[7:0], 32'hA5);
        check_eq("abort_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
        $finish;
    end

endmodule
`default_nettype wire
